// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl_pkg
//  Brief    : Shared state encoding and default widths for the pipeline controller.
//  Revision : 1.0
// ============================================================================
package pipeline_ctrl_pkg;

  localparam int C_NBITS_REG_DEF    = 5;
  localparam int C_NBITS_CNT_DEF    = 32;
  localparam int C_DRAIN_CYCLES_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Brief    : Combinational load-use hazard compare between EX load and ID sources.
//  Revision : 1.0
// ============================================================================
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int NBITS_REG = C_NBITS_REG_DEF
) (
  input  logic [NBITS_REG-1:0] i_id_rs,
  input  logic [NBITS_REG-1:0] i_id_rt,
  input  logic [NBITS_REG-1:0] i_ex_rt,
  input  logic                 i_ex_mem_read,
  output logic                 o_hazard
);

  // Register 0 is hard-wired, so a load into it never creates a dependency.
  assign o_hazard = i_ex_mem_read && (i_ex_rt != '0) &&
                    ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_controller
//  Brief    : Run/step/halt sequencer with stall, flush and bubble generation.
//  Revision : 1.0
// ============================================================================
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int NBITS_REG    = C_NBITS_REG_DEF,
  parameter int NBITS_CNT    = C_NBITS_CNT_DEF,
  parameter int DRAIN_CYCLES = C_DRAIN_CYCLES_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic                 i_halt_instr,
  input  logic [NBITS_REG-1:0] i_id_rs,
  input  logic [NBITS_REG-1:0] i_id_rt,
  input  logic [NBITS_REG-1:0] i_ex_rt,
  input  logic                 i_ex_mem_read,
  input  logic                 i_branch_taken,
  output logic                 o_pc_write,
  output logic                 o_if_id_write,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_bubble,
  output logic                 o_pipe_en,
  output logic                 o_halted,
  output logic [2:0]           o_state,
  output logic [NBITS_CNT-1:0] o_cycles
);

  localparam int C_DCW = $clog2(DRAIN_CYCLES + 1);

  state_t               r_state;
  logic [C_DCW-1:0]     r_drain_cnt;
  logic [NBITS_CNT-1:0] r_cycles;
  logic                 w_hazard;
  logic                 w_exec;
  logic                 w_halt_taken;

  hazard_detect #(
    .NBITS_REG (NBITS_REG)
  ) u_hazard_detect (
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_ex_rt       (i_ex_rt),
    .i_ex_mem_read (i_ex_mem_read),
    .o_hazard      (w_hazard)
  );

  assign w_exec       = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_halt_taken = w_exec && i_halt_instr && !i_branch_taken;

  // Outputs are forced low while reset is held, even before the state clears.
  always_comb begin
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_en      = 1'b0;
    o_halted       = 1'b0;
    if (i_rst_n) begin
      o_halted  = (r_state == ST_HALTED);
      o_pipe_en = w_exec || (r_state == ST_DRAIN);
      if (w_exec) begin
        if (i_branch_taken) begin
          o_if_id_flush = 1'b1;
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
        end else if (i_halt_instr) begin
          o_pc_write    = 1'b0;
          o_if_id_write = 1'b0;
        end else if (w_hazard) begin
          o_id_ex_bubble = 1'b1;
        end else begin
          o_pc_write    = 1'b1;
          o_if_id_write = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_cycles    <= '0;
    end else begin
      if (o_pipe_en && (r_cycles != {NBITS_CNT{1'b1}})) begin
        r_cycles <= r_cycles + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_run) begin
            r_state <= ST_RUN;
          end else if (i_step) begin
            r_state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (w_halt_taken) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end
        end
        ST_STEP: begin
          r_drain_cnt <= '0;
          r_state     <= w_halt_taken ? ST_DRAIN : ST_IDLE;
        end
        ST_DRAIN: begin
          if (r_drain_cnt == C_DCW'(DRAIN_CYCLES - 1)) begin
            r_state <= ST_HALTED;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_cycles = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_controller
//  Brief    : Directed self-checking bench for pipeline_controller.
//  Revision : 1.0
// ============================================================================
module tb_pipeline_controller;

  logic        clk = 1'b0;
  logic        rst_n, run, step, halt_instr, ex_mem_read, branch_taken;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, halted;
  logic [2:0]  state;
  logic [31:0] cycles;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_pipe_en, s_halted;
  logic [2:0]  s_state;
  logic [1:0]  s_cycles;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pipeline_controller dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step), .i_halt_instr(halt_instr),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rt(ex_rt), .i_ex_mem_read(ex_mem_read),
    .i_branch_taken(branch_taken), .o_pc_write(pc_write), .o_if_id_write(if_id_write),
    .o_if_id_flush(if_id_flush), .o_id_ex_bubble(id_ex_bubble), .o_pipe_en(pipe_en),
    .o_halted(halted), .o_state(state), .o_cycles(cycles)
  );

  // Narrow counter copy shares all stimulus and exposes saturation quickly.
  pipeline_controller #(.NBITS_CNT(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step), .i_halt_instr(halt_instr),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rt(ex_rt), .i_ex_mem_read(ex_mem_read),
    .i_branch_taken(branch_taken), .o_pc_write(s_pc_write), .o_if_id_write(s_if_id_write),
    .o_if_id_flush(s_if_id_flush), .o_id_ex_bubble(s_id_ex_bubble), .o_pipe_en(s_pipe_en),
    .o_halted(s_halted), .o_state(s_state), .o_cycles(s_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    run = 0; step = 0; halt_instr = 0; ex_mem_read = 0; branch_taken = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
    checks++; if (cycles !== 32'd0) begin errors++; $display("FAIL reset_cycles: got %0d exp 0", cycles); end
    checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, halted} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b exp 000000",
        {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, halted}); end
  endtask

  task automatic test_run();
    run = 1;
    #1;
    checks++; if (pipe_en !== 1'b0) begin errors++; $display("FAIL idle_pipe_en: got %b exp 0", pipe_en); end
    tick();
    run = 0;
    #1;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL run_state: got %0d exp 1", state); end
    checks++; if ({pc_write, if_id_write, pipe_en, if_id_flush, id_ex_bubble} !== 5'b11100) begin
      errors++; $display("FAIL run_controls: got %b exp 11100",
        {pc_write, if_id_write, pipe_en, if_id_flush, id_ex_bubble}); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (cycles !== 32'(i)) begin errors++; $display("FAIL run_cycles_%0d: got %0d exp %0d", i, cycles, i); end
    end
    tick();
    tick();
    checks++; if (cycles !== 32'd5) begin errors++; $display("FAIL run_cycles_5: got %0d exp 5", cycles); end
    checks++; if (s_cycles !== 2'd3) begin errors++; $display("FAIL cycles_saturate: got %0d exp 3", s_cycles); end
  endtask

  task automatic test_hazard();
    ex_mem_read = 1; ex_rt = 5; id_rt = 5; id_rs = 1;
    #1;
    checks++; if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      errors++; $display("FAIL hazard_rt: got %b exp 0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush}); end
    ex_rt = 0; id_rt = 0;
    #1;
    checks++; if ({pc_write, if_id_write, id_ex_bubble} !== 3'b110) begin
      errors++; $display("FAIL hazard_r0: got %b exp 110", {pc_write, if_id_write, id_ex_bubble}); end
    ex_rt = 7; id_rs = 7; id_rt = 2;
    #1;
    checks++; if ({pc_write, if_id_write, id_ex_bubble} !== 3'b001) begin
      errors++; $display("FAIL hazard_rs: got %b exp 001", {pc_write, if_id_write, id_ex_bubble}); end
    ex_mem_read = 0;
    #1;
    checks++; if ({pc_write, if_id_write, id_ex_bubble} !== 3'b110) begin
      errors++; $display("FAIL hazard_noload: got %b exp 110", {pc_write, if_id_write, id_ex_bubble}); end
  endtask

  task automatic test_branch_priority();
    ex_mem_read = 1; ex_rt = 7; id_rs = 7; branch_taken = 1;
    #1;
    checks++; if ({if_id_flush, pc_write, if_id_write, id_ex_bubble} !== 4'b1110) begin
      errors++; $display("FAIL branch_priority: got %b exp 1110",
        {if_id_flush, pc_write, if_id_write, id_ex_bubble}); end
    halt_instr = 1;
    tick();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL halt_flushed: got %0d exp 1", state); end
    clear_inputs();
  endtask

  task automatic test_step();
    do_reset();
    step = 1;
    tick();
    step = 0;
    #1;
    checks++; if (state !== 3'd2 || pipe_en !== 1'b1 || pc_write !== 1'b1) begin
      errors++; $display("FAIL step_active: got state %0d en %b pc %b exp 2 1 1", state, pipe_en, pc_write); end
    tick();
    checks++; if (state !== 3'd0 || cycles !== 32'd1 || pipe_en !== 1'b0) begin
      errors++; $display("FAIL step_return: got state %0d cyc %0d en %b exp 0 1 0", state, cycles, pipe_en); end
    tick();
    checks++; if (cycles !== 32'd1) begin errors++; $display("FAIL step_once: got %0d exp 1", cycles); end
    run = 1; step = 1;
    tick();
    clear_inputs();
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL run_step_both: got %0d exp 1", state); end
    do_reset();
    step = 1;
    tick();
    step = 0; halt_instr = 1;
    tick();
    halt_instr = 0;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL step_halt: got %0d exp 3", state); end
  endtask

  task automatic test_halt_drain();
    do_reset();
    run = 1;
    tick();
    run = 0;
    tick();
    halt_instr = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3;
    #1;
    checks++; if ({pc_write, if_id_write, id_ex_bubble, pipe_en} !== 4'b0001) begin
      errors++; $display("FAIL halt_cycle: got %b exp 0001", {pc_write, if_id_write, id_ex_bubble, pipe_en}); end
    tick();
    clear_inputs();
    run = 1; step = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3; branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (state !== 3'd3 || pipe_en !== 1'b1 || pc_write !== 1'b0 || if_id_write !== 1'b0 ||
                    if_id_flush !== 1'b0 || id_ex_bubble !== 1'b0) begin
        errors++; $display("FAIL drain_%0d: got state %0d en %b pc %b ifid %b fl %b bub %b exp 3 1 0 0 0 0",
          i, state, pipe_en, pc_write, if_id_write, if_id_flush, id_ex_bubble); end
      tick();
    end
    checks++; if (state !== 3'd4 || halted !== 1'b1 || pipe_en !== 1'b0 || cycles !== 32'd5) begin
      errors++; $display("FAIL halted_entry: got state %0d halted %b en %b cyc %0d exp 4 1 0 5",
        state, halted, pipe_en, cycles); end
    tick();
    tick();
    checks++; if (state !== 3'd4 || halted !== 1'b1 || cycles !== 32'd5) begin
      errors++; $display("FAIL halted_sticky: got state %0d halted %b cyc %0d exp 4 1 5", state, halted, cycles); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    run = 1;
    tick();
    run = 0; halt_instr = 1;
    tick();
    halt_instr = 0;
    tick();
    rst_n = 0;
    #1;
    checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, halted} !== 6'b0) begin
      errors++; $display("FAIL reset_gating: got %b exp 000000",
        {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, halted}); end
    tick();
    rst_n = 1;
    checks++; if (state !== 3'd0 || cycles !== 32'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_mid_drain: got state %0d cyc %0d halted %b exp 0 0 0", state, cycles, halted); end
    run = 1;
    tick();
    run = 0; halt_instr = 1;
    tick();
    halt_instr = 0;
    tick();
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL drain_restart: got %0d exp 3", state); end
    tick();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL drain_restart_end: got %0d exp 4", state); end
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout exp completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_run();
    test_hazard();
    test_branch_priority();
    test_step();
    test_halt_drain();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
